keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and produces a debounced 4-bit hex key code with a one-cycle press strobe.
- This is the input end of the front-panel digit path: key_code/key_valid replace the switch nibble and falling-edge button capture that feed the seven-segment digit shift register.
- Drives the rows, samples the columns, and suppresses bounce and multi-key ghosting.

Parameters:
SCAN_DIV, 1000, clocks each row is held active; must be >= 4
DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
col_in  input  4  keypad columns, active low, pulled up externally, asynchronous to clk
row_out  output  4  keypad row drive, active low, exactly one bit low at all times
key_code  output  4  code of last accepted key = row*4 + col
key_valid  output  1  one-cycle pulse when a press is accepted
key_held  output  1  high from acceptance until release is accepted
key_release  output  1  one-cycle pulse when a release is accepted

Behaviour:
- Reset values (async assert, sync release):
  - row_out=4'b1110; key_code=0; key_valid=0; key_held=0; key_release=0.
  - Synchronizer=4'b1111; all counters 0; FSM=IDLE.
- col_in passes through a 2-FF synchronizer before any use.
- Scan timing:
  - Dwell counter counts 0..SCAN_DIV-1; on wrap, row_out rotates left (1110->1101->1011->0111->1110).
  - Synchronized columns for the active row are sampled on the last dwell cycle (count==SCAN_DIV-1), before rotation.
  - Scanning never stops in any FSM state.
- Frame:
  - Four dwells, row 0 first.
  - Frame result is evaluated in the cycle after the row-3 sample:
    - NONE: zero pressed bits.
    - SINGLE(code): exactly one pressed bit across all rows; col = index of the low bit.
    - MULTI: two or more pressed bits.
- FSM (advances only on frame-result cycles):
  - IDLE:
    - SINGLE(c): cand=c, cnt=1; if DEBOUNCE_FRAMES==1 accept immediately, else go to CAND.
    - Otherwise stay in IDLE.
  - CAND:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_FRAMES, accept and go to HELD.
    - SINGLE(other): cand=other, cnt=1; stay in CAND.
    - NONE or MULTI: go to IDLE, cnt=0.
  - Accept: in the same cycle, key_code<=cand, key_valid=1 for exactly one clock, key_held<=1.
  - HELD:
    - Any frame in which cand's bit is pressed (including MULTI frames) sets rcnt=0.
    - Any frame in which cand's bit is not pressed increments rcnt.
    - When rcnt reaches DEBOUNCE_FRAMES: key_release=1 for one clock, key_held<=0, go to IDLE.
    - Other keys pressed while HELD never produce key_valid.
- key_code holds its value until the next accept; it is unchanged on release.
- Press latency: first frame containing the stable key through DEBOUNCE_FRAMES frames; key_valid asserts in the frame-result cycle of frame DEBOUNCE_FRAMES. Release latency is symmetric.
- key_valid and key_release are never high in the same cycle.
- Reset mid-scan or mid-debounce: immediate return to reset values; no pulses are generated by reset.
- Counter widths: dwell = clog2(SCAN_DIV); cnt/rcnt = clog2(DEBOUNCE_FRAMES+1). No wrap beyond terminal values.

Test Plan:
Bench uses SCAN_DIV=8, DEBOUNCE_FRAMES=3 (frame = 32 clocks). The keypad model pulls col c low iff key (r,c) is pressed and row_out[r]==0.

1. Reset release, no keys, run 200 clocks -> row_out cycles 1110,1101,1011,0111 every 8 clocks; key_valid, key_held and key_release stay 0.
2. Press key (2,1) steadily -> exactly one key_valid pulse with key_code=4'h9 at the end of the 3rd full frame; key_held=1. Release -> key_release pulse 3 frames later; key_code stays 9.
3. Key (0,3) bounces (toggling every 5 clocks) for 2 frames, then stable -> no key_valid during the bounce; a single key_valid with key_code=4'h3 after 3 stable frames.
4. Keys (1,0) and (3,3) pressed together from idle -> no key_valid. Then release (3,3) -> key_valid with code 4'h4 after 3 frames.
5. Hold (1,2) until accepted (code 6), then also press (0,0) -> no second key_valid. Release (1,2) with (0,0) still held -> key_release after 3 frames, then key_valid with code 0 after 3 further frames.
6. Assert rst for 3 clocks mid-CAND (after 2 matching frames) -> outputs return to reset values immediately. After release, 3 new stable frames are needed before key_valid.

Source files
------------

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with frame-based debounce and ghost rejection
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, CAND, HELD} state_t;

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] dwell;
  logic [1:0]    row_sel;
  logic [15:0]   frame;
  logic          frame_done;
  state_t        state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt, rcnt;
  logic [4:0]    n_pressed;
  logic [3:0]    hit_code;
  logic          single;

  // Pressed bits for a row land in the frame on the last dwell cycle of that row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 4'hF;
      sync2      <= 4'hF;
      dwell      <= '0;
      row_sel    <= 2'd0;
      row_out    <= 4'b1110;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      sync1      <= col_in;
      sync2      <= sync1;
      frame_done <= 1'b0;
      if (dwell == DWELL_LAST) begin
        dwell                        <= '0;
        row_out                      <= {row_out[2:0], row_out[3]};
        row_sel                      <= row_sel + 2'd1;
        frame[{row_sel, 2'b00} +: 4] <= ~sync2;
        frame_done                   <= (row_sel == 2'd3);
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  always_comb begin
    n_pressed = '0;
    hit_code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        n_pressed = n_pressed + 5'd1;
        hit_code  = 4'(i);
      end
    end
  end

  assign single = (n_pressed == 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      rcnt        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_done) begin
        case (state)
          IDLE: begin
            if (single) begin
              cand <= hit_code;
              cnt  <= CW'(1);
              if (DEBOUNCE_FRAMES == 1) begin
                key_code  <= hit_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rcnt      <= '0;
                state     <= HELD;
              end else begin
                state <= CAND;
              end
            end
          end
          CAND: begin
            if (single && hit_code == cand) begin
              cnt <= cnt + CW'(1);
              if (cnt == CNT_LAST) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rcnt      <= '0;
                state     <= HELD;
              end
            end else if (single) begin
              cand <= hit_code;
              cnt  <= CW'(1);
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
          HELD: begin
            // Extra keys alongside the held one still count as "held", never as a new press.
            if (frame[cand]) begin
              rcnt <= '0;
            end else if (rcnt == CNT_LAST) begin
              rcnt        <= rcnt + CW'(1);
              cnt         <= '0;
              key_release <= 1'b1;
              key_held    <= 1'b0;
              state       <= IDLE;
            end else begin
              rcnt <= rcnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
